// File: rtl/mod_q_sched.sv
// -----------------------------------------------------------------------------
// mod_q_sched
//
// Arbitrates two requesters onto one shared mod-q reducer. One operation is in
// flight at a time. An accepted operand is registered onto red_a, the reducer
// is kicked with a single-cycle red_start, and its result (or a timeout error
// when red_done never arrives) is presented as a held response until consumed.
//
// Parameters
//   N        operand / result width in bits
//   TIMEOUT  wait budget in cycles, counted from the red_start cycle (>= 2)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqX_valid/ready/a      requester X operand handshake (X = 0, 1)
//   red_start, red_a        reducer start pulse and registered operand
//   red_done, red_b         reducer completion strobe and result
//   rsp_valid/ready         response handshake
//   rsp_id, rsp_b, rsp_err  requester index, result, timeout flag
//   busy                    high whenever an operation is in progress
// -----------------------------------------------------------------------------
module mod_q_sched #(
  parameter int unsigned N       = 256,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  output logic         red_start,
  output logic [N-1:0] red_a,
  input  logic         red_done,
  input  logic [N-1:0] red_b,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [N-1:0] rsp_b,
  output logic         rsp_err,
  input  logic         rsp_ready,
  output logic         busy
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic            r_last_grant;
  logic            w_last_grant_d;
  logic [N-1:0]    r_red_a;
  logic [N-1:0]    w_red_a_d;
  logic [N-1:0]    r_rsp_b;
  logic [N-1:0]    w_rsp_b_d;
  logic            r_rsp_id;
  logic            w_rsp_id_d;
  logic            r_rsp_err;
  logic            w_rsp_err_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  logic            w_idle;
  logic            w_grant1;
  logic            w_hs;
  logic [CntW-1:0] w_cnt_inc;
  logic            w_timeout;

  // Round-robin between two: req1 wins when it is alone, or when both are
  // valid and req0 was the previous winner.
  assign w_idle     = (r_state == StIdle);
  assign w_grant1   = req1_valid & (~req0_valid | ~r_last_grant);
  assign req0_ready = w_idle & req0_valid & ~w_grant1;
  assign req1_ready = w_idle & w_grant1;
  // Any valid requester in IDLE is granted, so a handshake happens.
  assign w_hs       = w_idle & (req0_valid | req1_valid);

  // Counter value the current WAIT cycle would advance to; hitting TIMEOUT-1
  // ends the wait, which places the error response TIMEOUT cycles after
  // red_start.
  assign w_cnt_inc  = r_cnt + CntW'(1);
  assign w_timeout  = (w_cnt_inc == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_last_grant_d = r_last_grant;
    w_red_a_d      = r_red_a;
    w_rsp_b_d      = r_rsp_b;
    w_rsp_id_d     = r_rsp_id;
    w_rsp_err_d    = r_rsp_err;
    w_cnt_d        = r_cnt;

    unique case (r_state)
      StIdle: begin
        if (w_hs) begin
          w_red_a_d      = w_grant1 ? req1_a : req0_a;
          w_rsp_id_d     = w_grant1;
          w_last_grant_d = w_grant1;
          w_state_d      = StIssue;
        end
      end
      StIssue: begin
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        // red_done takes priority over a timeout landing in the same cycle.
        if (red_done) begin
          w_rsp_b_d   = red_b;
          w_rsp_err_d = 1'b0;
          w_state_d   = StResp;
        end else if (w_timeout) begin
          w_rsp_b_d   = '0;
          w_rsp_err_d = 1'b1;
          w_cnt_d     = w_cnt_inc;
          w_state_d   = StResp;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_red_a      <= '0;
      r_rsp_b      <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_last_grant <= w_last_grant_d;
      r_red_a      <= w_red_a_d;
      r_rsp_b      <= w_rsp_b_d;
      r_rsp_id     <= w_rsp_id_d;
      r_rsp_err    <= w_rsp_err_d;
      r_cnt        <= w_cnt_d;
    end
  end

  assign red_start = (r_state == StIssue);
  assign red_a     = r_red_a;
  assign rsp_valid = (r_state == StResp);
  assign rsp_id    = r_rsp_id;
  assign rsp_b     = r_rsp_b;
  assign rsp_err   = r_rsp_err;
  assign busy      = ~w_idle;

endmodule
